// File: rtl/quadratic_tg_if.sv
// Operand and result handshake channels between the traffic generator and the
// quadratic solver. Generator-side names are kept on both modports.
interface quadratic_tg_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] o_x;
  logic             o_valid_out;
  logic             o_ready_in;
  logic [WIDTH-1:0] i_y;
  logic             i_valid_in;
  logic             i_ready_out;

  modport master (
    output o_x, o_valid_out, i_ready_out,
    input  o_ready_in, i_y, i_valid_in
  );

  modport slave (
    input  o_x, o_valid_out, i_ready_out,
    output o_ready_in, i_y, i_valid_in
  );
endinterface

// File: rtl/quadratic_tg.sv
// Traffic generator/checker for the quadratic solver: issues x operands and
// checks each returned y, in order, against A*x^2 + B*x + C mod 2^WIDTH.
module quadratic_tg #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] A         = WIDTH'(101),
  parameter logic [WIDTH-1:0] B         = WIDTH'(59),
  parameter logic [WIDTH-1:0] C         = WIDTH'(76),
  parameter int               NUM_TESTS = 64,
  parameter logic [WIDTH-1:0] X_START   = '0,
  parameter logic [WIDTH-1:0] X_STEP    = WIDTH'(1),
  parameter int               DEPTH     = 8,
  parameter int               TIMEOUT   = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  quadratic_tg_if.master bus,
  output logic           done,
  output logic           error,
  output logic [15:0]    pass_count,
  output logic [15:0]    fail_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [15:0]   NUM_C     = 16'(NUM_TESTS);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] x_reg;
  logic             valid_reg, ready_reg, done_reg, error_reg;
  logic [15:0]      pass_reg, fail_reg;
  logic [15:0]      issued_reg, issued_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [TW-1:0]    idle_reg;
  logic             launch, push, res_xfer, pop, hit, timeout;

  // Scoreboard holds expected results; contents are don't-care while empty,
  // so only the pointers and occupancy need reset.
  logic [WIDTH-1:0] mem [DEPTH];

  function automatic logic [WIDTH-1:0] poly(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] sq;
    sq = x * x;
    return A * sq + B * x + C;
  endfunction

  always_comb begin
    launch      = start && (state_reg == IDLE || state_reg == DONE);
    push        = valid_reg && bus.o_ready_in;
    res_xfer    = bus.i_valid_in && ready_reg;
    pop         = res_xfer && (count_reg != '0);
    hit         = pop && (bus.i_y == mem[rd_ptr_reg]);
    timeout     = (state_reg == DRAIN) && !res_xfer && (idle_reg == IDLE_LAST);
    issued_next = launch ? '0 : issued_reg + 16'(push);
    count_next  = launch ? '0 : count_reg + CW'(push) - CW'(pop);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (start) state_next = RUN;
      RUN:        if (issued_next == NUM_C) state_next = DRAIN;
      DRAIN:      if (count_reg == '0 || timeout) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_reg      <= '0;
      valid_reg  <= 1'b0;
      ready_reg  <= 1'b0;
      done_reg   <= 1'b0;
      error_reg  <= 1'b0;
      pass_reg   <= '0;
      fail_reg   <= '0;
      issued_reg <= '0;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      idle_reg   <= '0;
    end else begin
      // Handshake outputs are computed from next-state values so they stay registered.
      valid_reg  <= (state_next == RUN) && (issued_next < NUM_C) && (count_next < DEPTH_C);
      ready_reg  <= (state_next == RUN) || (state_next == DRAIN);
      done_reg   <= (state_next == DONE);
      issued_reg <= issued_next;
      count_reg  <= count_next;
      if (launch) begin
        x_reg      <= X_START;
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        idle_reg   <= '0;
        error_reg  <= 1'b0;
        pass_reg   <= '0;
        fail_reg   <= '0;
      end else begin
        if (push) begin
          x_reg      <= x_reg + X_STEP;
          wr_ptr_reg <= wr_ptr_reg + AW'(1);
        end
        if (pop) rd_ptr_reg <= rd_ptr_reg + AW'(1);
        if (hit) begin
          if (pass_reg != 16'hFFFF) pass_reg <= pass_reg + 16'd1;
        end else if (res_xfer) begin
          if (fail_reg != 16'hFFFF) fail_reg <= fail_reg + 16'd1;
        end
        if ((res_xfer && !hit) || timeout) error_reg <= 1'b1;
        idle_reg <= (state_reg == DRAIN && !res_xfer) ? idle_reg + TW'(1) : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= poly(x_reg);
  end

  assign bus.o_x         = x_reg;
  assign bus.o_valid_out = valid_reg;
  assign bus.i_ready_out = ready_reg;
  assign done            = done_reg;
  assign error           = error_reg;
  assign pass_count      = pass_reg;
  assign fail_count      = fail_reg;
endmodule

// File: tb/tb_quadratic_tg.sv
// Bench for quadratic_tg: three generator instances, each driving a behavioural
// solver model with configurable latency, backpressure, corruption and drops.
module tb_quadratic_tg;
  localparam int NI = 3;
  localparam int          NT [NI] = '{64, 4, 1};
  localparam logic [15:0] XS [NI] = '{16'd0, 16'd0, 16'd1000};

  typedef struct {
    int          inst;
    int          idx;
    logic [15:0] x;
    logic [15:0] y;
  } vec_t;

  vec_t vecs [5];

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NI-1:0]       start_s = '0;
  logic [NI-1:0]       done_s, error_s;
  logic [NI-1:0][15:0] pass_s, fail_s;

  int   lat_c [NI];
  logic tog_c [NI];
  int   corrupt_c [NI];
  int   drop_c [NI];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] tbl_y(input int inst, input int idx);
    for (int k = 0; k < 5; k++)
      if (vecs[k].inst == inst && vecs[k].idx == idx) return vecs[k].y;
    return 16'hDEAD;
  endfunction

  function automatic logic [15:0] ref_y(input logic [15:0] x);
    longint v;
    v = 101 * longint'(x) * longint'(x) + 59 * longint'(x) + 76;
    return 16'(v % 65536);
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    quadratic_tg_if #(.WIDTH(16)) bus ();

    quadratic_tg #(.WIDTH(16), .NUM_TESTS(NT[gi]), .X_START(XS[gi])) u_dut (
      .clk(clk), .rst(rst), .start(start_s[gi]), .bus(bus),
      .done(done_s[gi]), .error(error_s[gi]),
      .pass_count(pass_s[gi]), .fail_count(fail_s[gi])
    );

    logic [15:0] q_y [$];
    int          q_t [$];
    logic [15:0] obs_x [64];
    int n_in, n_out, max_out, hold_viol, cyc;

    // Solver model: transfers are decided on the negedge, applied after the posedge.
    initial begin
      logic in_x, out_x, held;
      logic [15:0] xv, held_x, y;
      bus.o_ready_in = 1'b0;
      bus.i_valid_in = 1'b0;
      bus.i_y = '0;
      n_in = 0; n_out = 0; max_out = 0; hold_viol = 0; cyc = 0;
      held = 1'b0; held_x = '0;
      forever begin
        @(negedge clk);
        in_x  = rst && bus.o_valid_out && bus.o_ready_in;
        out_x = rst && bus.i_valid_in && bus.i_ready_out;
        xv    = bus.o_x;
        if (held && rst && (!bus.o_valid_out || bus.o_x != held_x)) hold_viol++;
        held   = rst && bus.o_valid_out && !bus.o_ready_in;
        held_x = bus.o_x;
        @(posedge clk); #1;
        cyc++;
        if (!rst || start_s[gi]) begin
          q_y.delete(); q_t.delete();
          n_in = 0; n_out = 0; max_out = 0; hold_viol = 0; held = 1'b0;
        end else begin
          if (in_x) begin
            y = (gi == 0) ? ref_y(xv) : tbl_y(gi, n_in);
            if (n_in == corrupt_c[gi]) y = y ^ 16'd1;
            if (n_in < 64) obs_x[n_in] = xv;
            if (n_in != drop_c[gi]) begin
              q_y.push_back(y);
              q_t.push_back(cyc + lat_c[gi] - 1);
            end
            n_in++;
          end
          if (out_x && q_y.size() > 0) begin
            void'(q_y.pop_front());
            void'(q_t.pop_front());
            n_out++;
          end
          if (n_in - n_out > max_out) max_out = n_in - n_out;
        end
        bus.o_ready_in = rst && (tog_c[gi] ? !bus.o_ready_in : 1'b1);
        bus.i_valid_in = 1'b0;
        bus.i_y = '0;
        if (q_y.size() > 0) begin
          bus.i_y = q_y[0];
          if (q_t[0] <= cyc) bus.i_valid_in = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse(input int i);
    @(negedge clk);
    start_s[i] = 1'b1;
    @(negedge clk);
    start_s[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget, output int el);
    el = 0;
    while (!done_s[i] && el < budget) begin
      @(posedge clk); #1;
      el++;
    end
    if (!done_s[i]) begin
      tests++;
      fails++;
      $display("FAIL done_wait[%0d]: done=0 after %0d cycles, expected 1", i, budget);
    end
  endtask

  initial begin
    int el;
    logic [15:0] ox;
    vecs[0] = '{1, 0, 16'd0,    16'd76};
    vecs[1] = '{1, 1, 16'd1,    16'd236};
    vecs[2] = '{1, 2, 16'd2,    16'd598};
    vecs[3] = '{1, 3, 16'd3,    16'd1162};
    vecs[4] = '{2, 0, 16'd1000, 16'd2564};
    for (int i = 0; i < NI; i++) begin
      lat_c[i] = 1; tog_c[i] = 1'b0; corrupt_c[i] = -1; drop_c[i] = -1;
    end

    repeat (3) @(negedge clk);
    #1;
    check("rst_o_x",        g_dut[0].bus.o_x, 0);
    check("rst_valid",      g_dut[0].bus.o_valid_out, 0);
    check("rst_ready",      g_dut[0].bus.i_ready_out, 0);
    check("rst_done",       done_s[0], 0);
    check("rst_error",      error_s[0], 0);
    check("rst_pass",       pass_s[0], 0);
    check("rst_fail",       fail_s[0], 0);
    @(negedge clk); #2 rst = 1'b1;

    // Start latency and wrap: X_START=1000, single operand.
    @(negedge clk);
    start_s[2] = 1'b1;
    @(posedge clk); #1;
    check("start_valid", g_dut[2].bus.o_valid_out, 1);
    check("start_o_x",   g_dut[2].bus.o_x, 1000);
    @(negedge clk);
    start_s[2] = 1'b0;
    wait_done(2, 50, el);
    check("wrap_pass",  pass_s[2], 1);
    check("wrap_fail",  fail_s[2], 0);
    check("wrap_error", error_s[2], 0);

    // Four operands against hand-computed results.
    pulse(1);
    wait_done(1, 50, el);
    check("n4_pass",  pass_s[1], 4);
    check("n4_fail",  fail_s[1], 0);
    check("n4_error", error_s[1], 0);
    check("n4_done",  done_s[1], 1);
    check("n4_valid_idle", g_dut[1].bus.o_valid_out, 0);
    check("n4_ready_idle", g_dut[1].bus.i_ready_out, 0);
    for (int k = 0; k < 5; k++) begin
      ox = (vecs[k].inst == 1) ? g_dut[1].obs_x[vecs[k].idx] : g_dut[2].obs_x[vecs[k].idx];
      check($sformatf("x_seq[%0d]", k), ox, vecs[k].x);
    end

    // Corrupted result (1162^1), error sticky in DONE.
    corrupt_c[1] = 3;
    pulse(1);
    wait_done(1, 50, el);
    check("bad_pass",  pass_s[1], 3);
    check("bad_fail",  fail_s[1], 1);
    check("bad_error", error_s[1], 1);
    repeat (5) @(posedge clk);
    #1;
    check("bad_error_held", error_s[1], 1);
    check("bad_done_held",  done_s[1], 1);
    corrupt_c[1] = -1;

    // Full 64-operand run, ideal solver.
    pulse(0);
    wait_done(0, 300, el);
    check("ideal_pass",  pass_s[0], 64);
    check("ideal_fail",  fail_s[0], 0);
    check("ideal_error", error_s[0], 0);

    // Toggling ready, latency 20: outstanding capped at DEPTH, operand held.
    tog_c[0] = 1'b1;
    lat_c[0] = 20;
    pulse(0);
    wait_done(0, 1000, el);
    check("bp_pass",      pass_s[0], 64);
    check("bp_fail",      fail_s[0], 0);
    check("bp_error",     error_s[0], 0);
    check("bp_max_out",   g_dut[0].max_out, 8);
    check("bp_hold_viol", g_dut[0].hold_viol, 0);
    tog_c[0] = 1'b0;
    lat_c[0] = 1;

    // Dropped last result: DRAIN timeout.
    drop_c[0] = 63;
    pulse(0);
    wait_done(0, 1300, el);
    check("to_pass",  pass_s[0], 63);
    check("to_fail",  fail_s[0], 0);
    check("to_error", error_s[0], 1);
    check("to_done",  done_s[0], 1);
    check("to_cycles_in_range", (el >= 1086 && el <= 1092), 1);
    drop_c[0] = -1;

    // Asynchronous reset mid-run, then a clean run.
    pulse(0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", g_dut[0].bus.o_valid_out, 0);
    check("mid_rst_ready", g_dut[0].bus.i_ready_out, 0);
    check("mid_rst_o_x",   g_dut[0].bus.o_x, 0);
    check("mid_rst_pass",  pass_s[0], 0);
    check("mid_rst_error", error_s[0], 0);
    check("mid_rst_done",  done_s[0], 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    pulse(0);
    wait_done(0, 300, el);
    check("post_rst_pass",  pass_s[0], 64);
    check("post_rst_fail",  fail_s[0], 0);
    check("post_rst_error", error_s[0], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
